// File: rtl/ieeedrv_rom_arb_if.sv
// Bus bundle between the shared-ROM arbiter, its drive/host requesters and the ROM.
// The slave modport is the arbiter's view; master is the requester/ROM side.
interface ieeedrv_rom_arb_if #(
  parameter int NDR       = 4,
  parameter int ADDRWIDTH = 14
);
  logic [NDR-1:0]       drv_req;
  logic [ADDRWIDTH-1:0] drv_addr [NDR];
  logic [NDR-1:0]       drv_ack;
  logic [7:0]           drv_data [NDR];

  logic [ADDRWIDTH-1:0] rom_addr;
  logic                 rom_wren;
  logic [7:0]           rom_wdata;
  logic [7:0]           rom_q;

  logic                 host_req;
  logic [ADDRWIDTH-1:0] host_addr;
  logic [7:0]           host_data;
  logic                 host_ack;
  logic                 busy;

  modport slave (
    input  drv_req, drv_addr, rom_q, host_req, host_addr, host_data,
    output drv_ack, drv_data, rom_addr, rom_wren, rom_wdata, host_ack, busy
  );

  modport master (
    output drv_req, drv_addr, rom_q, host_req, host_addr, host_data,
    input  drv_ack, drv_data, rom_addr, rom_wren, rom_wdata, host_ack, busy
  );
endinterface

// File: rtl/ieeedrv_rom_arb.sv
// Round-robin arbiter giving NDR drives one-at-a-time read access to a shared ROM.
// Define IEEEDRV_ROM_ARB_HOST_EN to enable the prioritised host write path.
module ieeedrv_rom_arb #(
  parameter int NDR       = 4,
  parameter int ADDRWIDTH = 14,
  parameter int RDLAT     = 2
) (
  input  logic             clk,
  input  logic             reset,
  ieeedrv_rom_arb_if.slave bus
);
  localparam int GW = (NDR > 1) ? $clog2(NDR) : 1;
  localparam int CW = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    DONE = 2'd2
`ifdef IEEEDRV_ROM_ARB_HOST_EN
    , WR = 2'd3
`endif
  } state_e;

  state_e               state_q, state_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic [GW-1:0]        last_grant_q, last_grant_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [ADDRWIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [7:0]           rom_wdata_q, rom_wdata_d;
  logic [NDR-1:0]       ack_q, ack_d;
  logic [7:0]           drv_data_q [NDR];
  logic [7:0]           drv_data_d [NDR];

  logic [GW-1:0]        pick;
  logic [GW-1:0]        cand;
  logic                 pick_vld;

  // Walk from the farthest candidate to the nearest so the drive closest
  // after last_grant is the one left standing.
  always_comb begin
    pick     = last_grant_q;
    pick_vld = 1'b0;
    cand     = '0;
    for (int i = NDR; i >= 1; i--) begin
      cand = GW'((int'(last_grant_q) + i) % NDR);
      if (bus.drv_req[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  // NOTE: the read data registers are architectural outputs that must read 0
  // after reset, so unlike a storage RAM they sit in the async reset branch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NDR - 1);
      cnt_q        <= '0;
      rom_addr_q   <= '0;
      rom_wdata_q  <= '0;
      ack_q        <= '0;
      for (int i = 0; i < NDR; i++) drv_data_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      rom_addr_q   <= rom_addr_d;
      rom_wdata_q  <= rom_wdata_d;
      ack_q        <= ack_d;
      drv_data_q   <= drv_data_d;
    end
  end

  // NOTE: every next-state signal is defaulted to its held value first so no
  // path through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    rom_addr_d   = rom_addr_q;
    rom_wdata_d  = rom_wdata_q;
    ack_d        = '0;
    drv_data_d   = drv_data_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
`ifdef IEEEDRV_ROM_ARB_HOST_EN
        if (bus.host_req) begin
          state_d     = WR;
          rom_addr_d  = bus.host_addr;
          rom_wdata_d = bus.host_data;
        end else
`endif
        if (pick_vld) begin
          state_d    = RD;
          grant_d    = pick;
          rom_addr_d = bus.drv_addr[pick];
        end
      end
      RD: begin
        if (cnt_q == CW'(RDLAT - 1)) state_d = DONE;
        else                         cnt_d   = cnt_q + 1'b1;
      end
      // rom_q becomes valid RDLAT clocks after rom_addr was registered,
      // which is exactly the DONE cycle.
      DONE: begin
        drv_data_d[grant_q] = bus.rom_q;
        ack_d[grant_q]      = 1'b1;
        last_grant_d        = grant_q;
        state_d             = IDLE;
      end
`ifdef IEEEDRV_ROM_ARB_HOST_EN
      WR: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (state_q != IDLE);
    bus.rom_addr  = rom_addr_q;
    bus.rom_wdata = rom_wdata_q;
    bus.drv_ack   = ack_q;
    bus.drv_data  = drv_data_q;
`ifdef IEEEDRV_ROM_ARB_HOST_EN
    bus.rom_wren  = (state_q == WR);
    bus.host_ack  = (state_q == WR);
`else
    bus.rom_wren  = 1'b0;
    bus.host_ack  = 1'b0;
`endif
  end
endmodule

// File: tb/tb_ieeedrv_rom_arb.sv
// Self-checking bench for ieeedrv_rom_arb: scoreboard of expected drive acks
// against a pipelined ROM model returning addr[7:0] after RDLAT clocks.
module tb_ieeedrv_rom_arb;
  localparam int NDR   = 4;
  localparam int AW    = 14;
  localparam int RDLAT = 2;

  typedef struct {
    int         drv;
    logic [7:0] data;
    int         ack_cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_chk;
  int   n_pass;
  exp_t sb [$];
  logic [7:0] mdl  [NDR];
  logic [7:0] pipe [RDLAT];

  ieeedrv_rom_arb_if #(.NDR(NDR), .ADDRWIDTH(AW)) bus ();

  ieeedrv_rom_arb #(.NDR(NDR), .ADDRWIDTH(AW), .RDLAT(RDLAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    pipe[0] <= bus.rom_addr[7:0];
    for (int i = 1; i < RDLAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.rom_q = pipe[RDLAT-1];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got time %0t want < 500000", $time);
    $fatal(1);
  end

  task automatic clear_inputs();
    bus.drv_req   = '0;
    for (int i = 0; i < NDR; i++) bus.drv_addr[i] = '0;
    bus.host_req  = 1'b0;
    bus.host_addr = '0;
    bus.host_data = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    for (int i = 0; i < NDR; i++) mdl[i] = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_ack(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.drv_ack !== '0) begin
        got = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    bit data_zero;
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    data_zero = 1'b1;
    for (int i = 0; i < NDR; i++) if (bus.drv_data[i] !== 8'h00) data_zero = 1'b0;
    n_chk++;
    if (bus.busy !== 1'b0 || bus.drv_ack !== '0 || bus.host_ack !== 1'b0)
      $display("FAIL reset_ctrl: got busy=%b ack=%b host_ack=%b want 0/0000/0",
               bus.busy, bus.drv_ack, bus.host_ack);
    else n_pass++;
    n_chk++;
    if (bus.rom_addr !== '0 || bus.rom_wren !== 1'b0 || bus.rom_wdata !== 8'h00)
      $display("FAIL reset_rom: got addr=%h wren=%b wdata=%h want 0000/0/00",
               bus.rom_addr, bus.rom_wren, bus.rom_wdata);
    else n_pass++;
    n_chk++;
    if (!data_zero)
      $display("FAIL reset_data: got %h %h %h %h want all 00",
               bus.drv_data[0], bus.drv_data[1], bus.drv_data[2], bus.drv_data[3]);
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    exp_t e;
    bit   got;
    @(negedge clk);
    bus.drv_req[1]  = 1'b1;
    bus.drv_addr[1] = 14'h0123;
    sb.push_back('{drv: 1, data: 8'h23, ack_cyc: cyc + 1 + 1 + RDLAT});
    @(negedge clk);
    n_chk++;
    if (bus.busy !== 1'b1 || bus.rom_addr !== 14'h0123)
      $display("FAIL single_rd_addr: got busy=%b rom_addr=%h want 1/0123", bus.busy, bus.rom_addr);
    else n_pass++;
    wait_ack(20, got);
    e = sb.pop_front();
    n_chk++;
    if (!got || bus.drv_ack !== 4'(1 << e.drv) || bus.drv_data[e.drv] !== e.data || cyc != e.ack_cyc)
      $display("FAIL single_rd_ack: got ack=%b data=%h cyc=%0d want drv=%0d data=%h cyc=%0d",
               bus.drv_ack, bus.drv_data[e.drv], cyc, e.drv, e.data, e.ack_cyc);
    else n_pass++;
    mdl[1] = 8'h23;
    bus.drv_req[1] = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.drv_ack !== '0 || bus.drv_data[1] !== 8'h23 || bus.busy !== 1'b0)
      $display("FAIL single_rd_pulse: got ack=%b data=%h busy=%b want 0000/23/0",
               bus.drv_ack, bus.drv_data[1], bus.busy);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    exp_t e;
    bit   got;
    int   first;
    apply_reset();
    reset = 1'b1;
    for (int i = 0; i < NDR; i++) begin
      bus.drv_addr[i] = AW'(16 * (i + 1) + i);
      bus.drv_req[i]  = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    first = cyc + 1 + 1 + RDLAT;
    for (int k = 0; k < 5; k++)
      sb.push_back('{drv: k % NDR, data: 8'(16 * ((k % NDR) + 1) + (k % NDR)),
                     ack_cyc: first + k * (RDLAT + 2)});
    for (int k = 0; k < 5; k++) begin
      bit others_ok;
      wait_ack(20, got);
      e = sb.pop_front();
      n_chk++;
      if (!got || bus.drv_ack !== 4'(1 << e.drv) || bus.drv_data[e.drv] !== e.data || cyc != e.ack_cyc)
        $display("FAIL rr_ack%0d: got ack=%b data=%h cyc=%0d want drv=%0d data=%h cyc=%0d",
                 k, bus.drv_ack, bus.drv_data[e.drv], cyc, e.drv, e.data, e.ack_cyc);
      else n_pass++;
      mdl[e.drv] = e.data;
      others_ok = 1'b1;
      for (int i = 0; i < NDR; i++) if (bus.drv_data[i] !== mdl[i]) others_ok = 1'b0;
      n_chk++;
      if (!others_ok)
        $display("FAIL rr_hold%0d: got %h %h %h %h want %h %h %h %h", k,
                 bus.drv_data[0], bus.drv_data[1], bus.drv_data[2], bus.drv_data[3],
                 mdl[0], mdl[1], mdl[2], mdl[3]);
      else n_pass++;
    end
    bus.drv_req = '0;
    @(negedge clk);
  endtask

  task automatic test_drop_during_rd();
    exp_t e;
    bit   got;
    @(negedge clk);
    bus.drv_req[3]  = 1'b1;
    bus.drv_addr[3] = 14'h0177;
    sb.push_back('{drv: 3, data: 8'h77, ack_cyc: cyc + 1 + 1 + RDLAT});
    @(negedge clk);
    bus.drv_req[3] = 1'b0;
    wait_ack(20, got);
    e = sb.pop_front();
    n_chk++;
    if (!got || bus.drv_ack !== 4'(1 << e.drv) || bus.drv_data[e.drv] !== e.data || cyc != e.ack_cyc)
      $display("FAIL drop_rd_ack: got ack=%b data=%h cyc=%0d want drv=%0d data=%h cyc=%0d",
               bus.drv_ack, bus.drv_data[e.drv], cyc, e.drv, e.data, e.ack_cyc);
    else n_pass++;
    mdl[3] = 8'h77;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_rd();
    exp_t e;
    bit   got;
    bit   zero_ok;
    bit   stray_ack;
    int   start;
    @(negedge clk);
    bus.drv_req[2]  = 1'b1;
    bus.drv_addr[2] = 14'h0099;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    zero_ok = (bus.busy === 1'b0) && (bus.drv_ack === '0) && (bus.rom_addr === '0) &&
              (bus.rom_wren === 1'b0) && (bus.host_ack === 1'b0) && (bus.rom_wdata === 8'h00);
    for (int i = 0; i < NDR; i++) if (bus.drv_data[i] !== 8'h00) zero_ok = 1'b0;
    n_chk++;
    if (!zero_ok)
      $display("FAIL rst_mid_rd_zero: got busy=%b ack=%b addr=%h d=%h %h %h %h want all 0",
               bus.busy, bus.drv_ack, bus.rom_addr,
               bus.drv_data[0], bus.drv_data[1], bus.drv_data[2], bus.drv_data[3]);
    else n_pass++;
    for (int i = 0; i < NDR; i++) mdl[i] = '0;
    bus.drv_req = '0;
    stray_ack = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus.drv_ack !== '0) stray_ack = 1'b1;
    end
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.drv_ack !== '0 || bus.busy !== 1'b0) stray_ack = 1'b1;
    end
    n_chk++;
    if (stray_ack) $display("FAIL rst_mid_rd_noack: got a drv_ack/busy after reset want none");
    else n_pass++;
    bus.drv_addr[0] = 14'h0201;
    bus.drv_addr[2] = 14'h0302;
    bus.drv_req[0]  = 1'b1;
    bus.drv_req[2]  = 1'b1;
    start = cyc + 1 + 1 + RDLAT;
    sb.push_back('{drv: 0, data: 8'h01, ack_cyc: start});
    sb.push_back('{drv: 2, data: 8'h02, ack_cyc: start + RDLAT + 2});
    for (int k = 0; k < 2; k++) begin
      wait_ack(20, got);
      e = sb.pop_front();
      n_chk++;
      if (!got || bus.drv_ack !== 4'(1 << e.drv) || bus.drv_data[e.drv] !== e.data || cyc != e.ack_cyc)
        $display("FAIL rst_mid_rd_after%0d: got ack=%b data=%h cyc=%0d want drv=%0d data=%h cyc=%0d",
                 k, bus.drv_ack, bus.drv_data[e.drv], cyc, e.drv, e.data, e.ack_cyc);
      else n_pass++;
      mdl[e.drv] = e.data;
      bus.drv_req[e.drv] = 1'b0;
    end
    @(negedge clk);
  endtask

`ifdef IEEEDRV_ROM_ARB_HOST_EN
  task automatic test_host_priority();
    exp_t e;
    bit   got;
    apply_reset();
    @(negedge clk);
    bus.host_req    = 1'b1;
    bus.host_addr   = 14'h3FFF;
    bus.host_data   = 8'hA5;
    bus.drv_req[0]  = 1'b1;
    bus.drv_addr[0] = 14'h0055;
    sb.push_back('{drv: 0, data: 8'h55, ack_cyc: cyc + 1 + 2 + 1 + RDLAT});
    @(negedge clk);
    n_chk++;
    if (bus.rom_wren !== 1'b1 || bus.host_ack !== 1'b1 || bus.rom_addr !== 14'h3FFF ||
        bus.rom_wdata !== 8'hA5 || bus.drv_ack !== '0)
      $display("FAIL host_wr: got wren=%b hack=%b addr=%h wdata=%h ack=%b want 1/1/3fff/a5/0000",
               bus.rom_wren, bus.host_ack, bus.rom_addr, bus.rom_wdata, bus.drv_ack);
    else n_pass++;
    bus.host_req = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.rom_wren !== 1'b0 || bus.host_ack !== 1'b0)
      $display("FAIL host_wr_len: got wren=%b hack=%b want 0/0", bus.rom_wren, bus.host_ack);
    else n_pass++;
    wait_ack(20, got);
    e = sb.pop_front();
    n_chk++;
    if (!got || bus.drv_ack !== 4'(1 << e.drv) || bus.drv_data[e.drv] !== e.data || cyc != e.ack_cyc)
      $display("FAIL host_then_rd: got ack=%b data=%h cyc=%0d want drv=%0d data=%h cyc=%0d",
               bus.drv_ack, bus.drv_data[e.drv], cyc, e.drv, e.data, e.ack_cyc);
    else n_pass++;
    bus.drv_req[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_host_wait();
    exp_t e;
    bit   got;
    bit   early_wr;
    @(negedge clk);
    bus.drv_req[2]  = 1'b1;
    bus.drv_addr[2] = 14'h02C4;
    sb.push_back('{drv: 2, data: 8'hC4, ack_cyc: cyc + 1 + 1 + RDLAT});
    early_wr = 1'b0;
    got      = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.rom_wren !== 1'b0 || bus.host_ack !== 1'b0) early_wr = 1'b1;
      if (i == 0) begin
        bus.host_req  = 1'b1;
        bus.host_addr = 14'h1234;
        bus.host_data = 8'h5A;
      end
      if (bus.drv_ack !== '0) got = 1'b1;
    end
    e = sb.pop_front();
    n_chk++;
    if (!got || bus.drv_ack !== 4'(1 << e.drv) || bus.drv_data[e.drv] !== e.data || cyc != e.ack_cyc)
      $display("FAIL host_wait_rd: got ack=%b data=%h cyc=%0d want drv=%0d data=%h cyc=%0d",
               bus.drv_ack, bus.drv_data[e.drv], cyc, e.drv, e.data, e.ack_cyc);
    else n_pass++;
    n_chk++;
    if (early_wr) $display("FAIL host_wait_nopreempt: got rom_wren/host_ack during read want 0");
    else n_pass++;
    bus.drv_req[2] = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.rom_wren !== 1'b1 || bus.host_ack !== 1'b1 || bus.rom_addr !== 14'h1234 || bus.rom_wdata !== 8'h5A)
      $display("FAIL host_wait_wr: got wren=%b hack=%b addr=%h wdata=%h want 1/1/1234/5a",
               bus.rom_wren, bus.host_ack, bus.rom_addr, bus.rom_wdata);
    else n_pass++;
    bus.host_req = 1'b0;
    @(negedge clk);
  endtask
`else
  task automatic test_host_disabled();
    exp_t e;
    bit   got;
    bit   host_seen;
    @(negedge clk);
    bus.host_req    = 1'b1;
    bus.host_addr   = 14'h3FFF;
    bus.host_data   = 8'hA5;
    bus.drv_req[1]  = 1'b1;
    bus.drv_addr[1] = 14'h0042;
    sb.push_back('{drv: 1, data: 8'h42, ack_cyc: cyc + 1 + 1 + RDLAT});
    host_seen = 1'b0;
    got       = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.rom_wren !== 1'b0 || bus.host_ack !== 1'b0 || bus.rom_wdata !== 8'h00) host_seen = 1'b1;
      if (bus.drv_ack !== '0) got = 1'b1;
    end
    e = sb.pop_front();
    n_chk++;
    if (!got || bus.drv_ack !== 4'(1 << e.drv) || bus.drv_data[e.drv] !== e.data || cyc != e.ack_cyc)
      $display("FAIL nohost_rd: got ack=%b data=%h cyc=%0d want drv=%0d data=%h cyc=%0d",
               bus.drv_ack, bus.drv_data[e.drv], cyc, e.drv, e.data, e.ack_cyc);
    else n_pass++;
    bus.drv_req[1] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.rom_wren !== 1'b0 || bus.host_ack !== 1'b0 || bus.busy !== 1'b0) host_seen = 1'b1;
    end
    n_chk++;
    if (host_seen) $display("FAIL nohost_quiet: got rom_wren/host_ack/busy activity want none");
    else n_pass++;
    bus.host_req = 1'b0;
  endtask
`endif

  initial begin
    n_chk  = 0;
    n_pass = 0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_drop_during_rd();
    test_reset_mid_rd();
`ifdef IEEEDRV_ROM_ARB_HOST_EN
    test_host_priority();
    test_host_wait();
`else
    test_host_disabled();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ieeedrv_rom_arb.md
IEEEDRV_ROM_ARB -- requirements
Module: ieeedrv_rom_arb

Interface
REQ-001 Parameter NDR, default 4: number of drive requesters, range 1..4.
REQ-002 Parameter ADDRWIDTH, default 14: shared ROM address width.
REQ-003 Parameter RDLAT, default 2: ROM read latency in clocks, from rom_addr registered to rom_q valid, range 1..3.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 drv_req  in  NDR  per-drive read request, level, held until drv_ack.
REQ-007 drv_addr  in  ADDRWIDTH x NDR (unpacked [NDR])  per-drive read address, stable while drv_req is high.
REQ-008 drv_ack  out  NDR  one-cycle pulse, read data valid in drv_data.
REQ-009 drv_data  out  8 x NDR (unpacked [NDR])  per-drive read data, held until that drive's next ack.
REQ-010 rom_addr  out  ADDRWIDTH  registered ROM address.
REQ-011 rom_wren  out  1  ROM write enable.
REQ-012 rom_wdata  out  8  ROM write data.
REQ-013 rom_q  in  8  ROM read data.
REQ-014 host_req  in  1  host ROM write request, level, held until host_ack.
REQ-015 host_addr  in  ADDRWIDTH  host write address.
REQ-016 host_data  in  8  host write data.
REQ-017 host_ack  out  1  one-cycle pulse, write performed.
REQ-018 busy  out  1  high whenever the state is not IDLE.

Function
REQ-019 FSM states SHALL be IDLE, RD, DONE and WR; exactly one ROM access is outstanding at any time.
REQ-020 In IDLE, host_req high SHALL win over all drv_req and SHALL move to WR; otherwise any drv_req high SHALL move to RD.
REQ-021 Drive selection SHALL be round-robin: search starts at last_grant+1 modulo NDR and takes the first drive with drv_req high.
REQ-022 On entering RD, rom_addr SHALL equal drv_addr of the granted drive; rom_addr SHALL hold for RDLAT cycles.
REQ-023 After RDLAT cycles in RD, the FSM SHALL capture rom_q into drv_data of the granted drive, enter DONE, and pulse drv_ack of that drive only.
REQ-024 Read latency SHALL be: drv_req sampled in IDLE at edge N -> drv_ack high in the cycle after edge N+1+RDLAT.
REQ-025 DONE SHALL last one cycle, update last_grant to the granted drive, and return to IDLE; back-to-back grant spacing is RDLAT+2 cycles.
REQ-026 WR SHALL last exactly one cycle with rom_wren=1, rom_addr=host_addr, rom_wdata=host_data and host_ack=1, then return to IDLE.
REQ-027 rom_wren SHALL be 0 in every state other than WR.
REQ-028 A drive dropping drv_req during RD SHALL NOT abort the access; the read completes and drv_ack still pulses.
REQ-029 host_req rising during RD or DONE SHALL wait for IDLE; the host never preempts an access in flight.
REQ-030 A drive holding drv_req through its ack SHALL be re-arbitrated normally; with all NDR drives requesting, each drive SHALL be served once per NDR grants.
REQ-031 drv_data of non-granted drives SHALL never change.

Reset
REQ-032 reset high SHALL force IDLE, last_grant=NDR-1, rom_addr=0, rom_wren=0, rom_wdata=0, drv_ack=0, drv_data=0 for all drives, host_ack=0 and busy=0, regardless of clk.
REQ-033 reset asserted mid-RD or mid-WR SHALL discard the access with no ack; the first grant after reset goes to drive 0 if requesting.

Configuration
REQ-034 Macro IEEEDRV_ROM_ARB_HOST_EN defined: host write path active per REQ-020, REQ-026 and REQ-029.
REQ-035 Macro IEEEDRV_ROM_ARB_HOST_EN undefined: WR state absent, host_* inputs ignored, host_ack and rom_wren tied 0, rom_wdata tied 0; ports remain present.

Verification
REQ-036 RDLAT=2, drv_req[1]=1, addr 14'h0123, rom_q models addr[7:0] -> drv_ack[1] pulses 3 cycles after sampling, drv_data[1]=8'h23.
REQ-037 All four drives request continuously from reset -> grant order 0,1,2,3,0, consecutive acks 4 cycles apart.
REQ-038 host_req with addr 14'h3FFF, data 8'hA5 together with drv_req[0] -> WR first with rom_wren one cycle, host_ack, then drive 0 read.
REQ-039 host_req rising in the first RD cycle of drive 2 -> drive 2 acks first, then WR follows; rom_wren never high during RD.
REQ-040 reset asserted in the second RD cycle -> no drv_ack, all outputs 0 immediately, next request served normally.
REQ-041 Build without IEEEDRV_ROM_ARB_HOST_EN, host_req held high -> rom_wren and host_ack stay 0, drive reads unaffected.
